block_xfer_seq: RTL
===================

BLOCK_XFER_SEQ -- requirements
Module: block_xfer_seq

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The module SHALL expose these ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  async active-low reset.
- start_i  in  1  begin a block transfer; sampled in IDLE only.
- load_i  in  1  1 = memory-to-register (LDM), 0 = register-to-memory (STM); captured at start.
- incr_i  in  1  1 = increment-after, 0 = decrement-before; captured at start.
- reg_list_i  in  16  bit n set = register n transfers; captured at start.
- base_addr_i  in  32  base address; captured at start.
- reg_rdata_i  in  32  data from the register-file read port addressed by reg_raddr_o (combinational).
- mem_ready_i  in  1  memory accepts/completes the current request this cycle.
- mem_rdata_i  in  32  load data, valid when mem_ready_i=1.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle completion pulse.
- reg_raddr_o  out  4  register-file read address.
- reg_we_o  out  1  register-file write enable.
- reg_waddr_o  out  4  register-file write address.
- reg_wdata_o  out  32  register-file write data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write (STM).
- mem_addr_o  out  32  word address of current transfer.
- mem_wdata_o  out  32  store data.
- wb_base_o  out  32  updated base; valid with done_o.

Function
REQ-003 The FSM SHALL have states IDLE, XFER, DONE.
REQ-004 IDLE + start_i=1 SHALL capture all inputs and go to XFER if reg_list_i != 0, else to DONE.
REQ-005 start_i SHALL be ignored in XFER and DONE.
REQ-006 Transfers SHALL proceed in ascending register index; current register = lowest set bit of the remaining mask.
REQ-007 For N set bits and k = 0..N-1: increment-after addr = base + 4k; decrement-before addr = base - 4N + 4k.
REQ-008 wb_base_o SHALL be base + 4N (incr) or base - 4N (decr), computed mod 2^32; for N=0 it SHALL equal base.
REQ-009 In XFER, mem_req_o=1 and mem_we_o=!load; mem_addr_o and mem_we_o SHALL remain stable until mem_ready_i=1.
REQ-010 STM: reg_raddr_o = current register; mem_wdata_o = reg_rdata_i; r15 SHALL be stored as the value on reg_rdata_i.
REQ-011 LDM: on a cycle with mem_ready_i=1, the block SHALL register mem_rdata_i and the current index, then pulse reg_we_o exactly one cycle later with reg_waddr_o/reg_wdata_o.
REQ-012 On mem_ready_i=1, the current bit SHALL clear; if the mask becomes empty, the FSM SHALL go to DONE, otherwise it SHALL issue the next transfer the following cycle with no idle bubble.
REQ-013 DONE SHALL last one cycle with done_o=1 and busy_o=0, then return to IDLE.
REQ-014 busy_o SHALL be 1 exactly while in XFER.
REQ-015 The final LDM reg_we_o pulse SHALL coincide with done_o.
REQ-016 Outside XFER: mem_req_o=0, mem_we_o=0, and reg_we_o=0, except for the REQ-011 trailing pulse.
REQ-017 Latency SHALL be: start at cycle t -> first mem_req_o at t+1; with zero-wait memory, done_o at t+N+1.

Reset
REQ-018 rst_ni=0 SHALL immediately force IDLE, clear the mask, and set every output to 0, including addresses and data.
REQ-019 Reset asserted mid-transfer SHALL abort the sequence with no further reg_we_o or mem_req_o, and no done_o.

Verification
REQ-020 STM, list=16'h00A0 (r5, r7), base=0x100, incr=1, ready always 1 -> mem writes to 0x100 (r5 data) then 0x104 (r7 data); done_o at t+3; wb_base_o=0x108.
REQ-021 LDM, list=16'h8001 (r0, r15), base=0x200, incr=0, ready always 1 -> reads 0x1F8 -> r0 and 0x1FC -> r15; reg_we_o pulses at t+2 and t+3; wb_base_o=0x1F8.
REQ-022 LDM of one register with mem_ready_i held 0 for 3 cycles -> mem_req_o held 4 cycles with stable mem_addr_o; single reg_we_o pulse after ready.
REQ-023 list=0, start, base=0x40 -> done_o at t+1; no mem_req_o; wb_base_o=0x40.
REQ-024 start_i pulsed while busy_o=1 -> ignored; the in-flight sequence completes unchanged.
REQ-025 rst_ni low during the 2nd transfer of 4 -> all outputs 0 at once; after release, IDLE with no spurious done_o or reg_we_o.

Source files
------------

// File: rtl/block_xfer_seq_if.sv
// Handshake/bus bundle for the block transfer sequencer: control inputs,
// register-file ports and the memory request channel.
interface block_xfer_seq_if;
  logic        start_i;
  logic        load_i;
  logic        incr_i;
  logic [15:0] reg_list_i;
  logic [31:0] base_addr_i;
  logic [31:0] reg_rdata_i;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  reg_raddr_o;
  logic        reg_we_o;
  logic [3:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] wb_base_o;

  modport slave (
    input  start_i, load_i, incr_i, reg_list_i, base_addr_i,
           reg_rdata_i, mem_ready_i, mem_rdata_i,
    output busy_o, done_o, reg_raddr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wb_base_o
  );

  modport master (
    output start_i, load_i, incr_i, reg_list_i, base_addr_i,
           reg_rdata_i, mem_ready_i, mem_rdata_i,
    input  busy_o, done_o, reg_raddr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wb_base_o
  );
endinterface

// File: rtl/block_xfer_seq.sv
// Block load/store-multiple sequencer: walks a 16-bit register list in
// ascending order, issuing one word transfer per set bit.
module block_xfer_seq (
  input  logic              clk_i,
  input  logic              rst_ni,
  block_xfer_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] mask_q;
  logic        load_q;
  logic [31:0] addr_q;
  logic [31:0] wb_q;
  logic        ld_pend_q;
  logic [3:0]  ld_idx_q;
  logic [31:0] ld_data_q;

  logic [3:0]  cur_idx;
  logic [15:0] mask_next;
  logic [5:0]  list_cnt;
  logic [31:0] span;
  logic        xfer;
  logic        accept;
  logic        store;

  // Scan downward so the last hit is the lowest set bit.
  always_comb begin
    cur_idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (mask_q[i-1]) cur_idx = 4'(i - 1);
    end
  end

  always_comb begin
    list_cnt = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      list_cnt = list_cnt + 6'(bus.reg_list_i[i]);
    end
  end

  assign span      = {24'd0, list_cnt, 2'b00};
  assign mask_next = mask_q & (mask_q - 16'd1);
  assign xfer      = (state_q == XFER);
  assign accept    = xfer && bus.mem_ready_i;
  assign store     = xfer && !load_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start_i) state_d = (bus.reg_list_i != '0) ? XFER : DONE;
      XFER: if (accept && (mask_next == '0)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decrement-before starts at the lowest address, so both modes then step upward.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q    <= '0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      wb_q      <= '0;
      ld_pend_q <= 1'b0;
      ld_idx_q  <= '0;
      ld_data_q <= '0;
    end else begin
      ld_pend_q <= accept && load_q;
      if (state_q == IDLE && bus.start_i) begin
        mask_q <= bus.reg_list_i;
        load_q <= bus.load_i;
        addr_q <= bus.incr_i ? bus.base_addr_i : bus.base_addr_i - span;
        wb_q   <= bus.incr_i ? bus.base_addr_i + span : bus.base_addr_i - span;
      end else if (accept) begin
        mask_q <= mask_next;
        addr_q <= addr_q + 32'd4;
        if (load_q) begin
          ld_idx_q  <= cur_idx;
          ld_data_q <= bus.mem_rdata_i;
        end
      end
    end
  end

  assign bus.busy_o      = xfer;
  assign bus.done_o      = (state_q == DONE);
  assign bus.mem_req_o   = xfer;
  assign bus.mem_we_o    = store;
  assign bus.mem_addr_o  = xfer ? addr_q : '0;
  assign bus.reg_raddr_o = store ? cur_idx : '0;
  assign bus.mem_wdata_o = store ? bus.reg_rdata_i : '0;
  assign bus.reg_we_o    = ld_pend_q;
  assign bus.reg_waddr_o = ld_pend_q ? ld_idx_q : '0;
  assign bus.reg_wdata_o = ld_pend_q ? ld_data_q : '0;
  assign bus.wb_base_o   = (state_q == DONE) ? wb_q : '0;

endmodule
